// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port.
// It accepts one word load or store at a time through a req/ack handshake and
// inserts LATENCY wait states before it answers. The storage array has no
// reset, so its contents survive rst. The FSM state, the captured request and
// the response registers are all cleared asynchronously.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH];

  // Access controls for the edge that enters RESP.
  logic              acc_go_d;
  logic              acc_we_d;
  logic [31:0]       acc_addr_d;
  logic [31:0]       acc_wdata_d;
  logic [3:0]        acc_be_d;
  logic              acc_err_d;
  logic [ADDR_W-1:0] acc_idx_d;
  logic              wr_en_d;

  // Choose the request that the access uses. With zero latency, the live
  // inputs are used on the capturing edge. Otherwise the captured copy is used.
  always_comb begin
    acc_go_d    = 1'b0;
    acc_we_d    = we_q;
    acc_addr_d  = addr_q;
    acc_wdata_d = wdata_q;
    acc_be_d    = be_q;
    if (state_q == IDLE) begin
      acc_we_d    = we;
      acc_addr_d  = addr;
      acc_wdata_d = wdata;
      acc_be_d    = be;
      acc_go_d    = req && (LATENCY == 0);
    end else if (state_q == WAIT) begin
      acc_go_d    = (cnt_q == 4'd0);
    end
    // Misaligned or out-of-range byte addresses are errors and never touch storage.
    acc_err_d = (acc_addr_d[1:0] != 2'b00) || ((acc_addr_d >> (ADDR_W + 2)) != 32'd0);
    acc_idx_d = acc_addr_d[ADDR_W+1:2];
    wr_en_d   = acc_go_d && acc_we_d && !acc_err_d;
  end

  // Byte-enabled storage write. There is no reset, so contents persist.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be_d[i]) mem[acc_idx_d][8*i +: 8] <= acc_wdata_d[8*i +: 8];
      end
    end
  end

  // Handshake FSM with request capture and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (acc_go_d) begin
        ack_q   <= 1'b1;
        err_q   <= acc_err_d;
        rdata_q <= (!acc_err_d && !acc_we_d) ? mem[acc_idx_d] : 32'd0;
      end
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. It instantiates a LATENCY=2 unit
// and a LATENCY=0 unit. Inputs are driven on the falling edge, and outputs are
// sampled on the falling edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [3:0]  be0 = 4'd0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .be(be0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  // Run one transaction on the LATENCY=2 unit. lat is the number of falling
  // edges from driving req to seeing ack, or -1 on timeout.
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] rd, output logic e,
                      output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = -1; rd = 32'hFFFF_FFFF; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({ack, err, busy} !== 3'b000 || rdata !== 32'd0)
        $display("FAIL reset_idle cyc%0d ack=%b err=%b busy=%b rdata=%h want 0/0/0/0", c, ack, err, busy, rdata);
      else passed++;
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || ack !== 1'b0) $display("FAIL store_wait1 busy=%b ack=%b want 1/0", busy, ack);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || ack !== 1'b0) $display("FAIL store_wait2 busy=%b ack=%b want 1/0", busy, ack);
    else passed++;
    @(negedge clk);
    total++;
    if (ack !== 1'b1 || err !== 1'b0 || rdata !== 32'd0)
      $display("FAIL store_ack ack=%b err=%b rdata=%h want 1/0/0", ack, err, rdata);
    else passed++;
    req = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || busy !== 1'b0) $display("FAIL store_ack_once ack=%b busy=%b want 0/0", ack, busy);
    else passed++;
    xact(1'b0, 32'h10, 32'd0, 4'h0, rd, e, lat);
    total++;
    if (lat !== 3 || rd !== 32'hDEADBEEF || e !== 1'b0)
      $display("FAIL load_full lat=%0d rdata=%h err=%b want 3/deadbeef/0", lat, rd, e);
    else passed++;
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b0) $display("FAIL be_store lat=%0d err=%b want 3/0", lat, e);
    else passed++;
    xact(1'b0, 32'h10, 32'd0, 4'h0, rd, e, lat);
    total++;
    if (rd !== 32'hDE22BE44 || e !== 1'b0) $display("FAIL be_load rdata=%h err=%b want de22be44/0", rd, e);
    else passed++;
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b0) $display("FAIL be_zero_store lat=%0d err=%b want 3/0", lat, e);
    else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    xact(1'b1, 32'h12, 32'hAAAAAAAA, 4'hF, rd, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b1 || rd !== 32'd0)
      $display("FAIL err_misalign lat=%0d err=%b rdata=%h want 3/1/0", lat, e, rd);
    else passed++;
    xact(1'b0, 32'h1000, 32'd0, 4'h0, rd, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b1 || rd !== 32'd0)
      $display("FAIL err_range lat=%0d err=%b rdata=%h want 3/1/0", lat, e, rd);
    else passed++;
    xact(1'b0, 32'h10, 32'd0, 4'h0, rd, e, lat);
    total++;
    if (rd !== 32'hDE22BE44 || e !== 1'b0)
      $display("FAIL err_nowrite rdata=%h err=%b want de22be44/0", rd, e);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat;
    int t1, t2; logic [31:0] r1, r2;
    xact(1'b1, 32'h14, 32'h5A5A0014, 4'hF, rd, e, lat);
    t1 = -1; t2 = -1; r1 = 32'd0; r2 = 32'd0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (t1 >= 0 && i == t1 + 1) addr = 32'h14;
      if (ack) begin
        if (t1 < 0) begin t1 = i; r1 = rdata; end
        else begin t2 = i; r2 = rdata; break; end
      end
    end
    req = 1'b0;
    total++;
    if (t1 < 0 || t2 < 0 || t2 - t1 !== 4) $display("FAIL b2b_spacing t1=%0d t2=%0d want 4 apart", t1, t2);
    else passed++;
    total++;
    if (r1 !== 32'hDE22BE44 || r2 !== 32'h5A5A0014)
      $display("FAIL b2b_data r1=%h r2=%h want de22be44/5a5a0014", r1, r2);
    else passed++;
  endtask

  task automatic test_back_to_back_l0();
    int t1, t2, ts; logic [31:0] r1, r2;
    ts = -1;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hA5A5A5A5; be0 = 4'hF;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack0) begin ts = i; break; end
    end
    req0 = 1'b0;
    total++;
    if (ts !== 1) $display("FAIL l0_store_latency got=%0d want 1", ts);
    else passed++;
    t1 = -1; t2 = -1; r1 = 32'd0; r2 = 32'd0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (t1 >= 0 && i == t1 + 1) addr0 = 32'h14;
      if (ack0) begin
        if (t1 < 0) begin t1 = i; r1 = rdata0; end
        else begin t2 = i; r2 = rdata0; break; end
      end
    end
    req0 = 1'b0;
    total++;
    if (t1 < 0 || t2 < 0 || t2 - t1 !== 2) $display("FAIL l0_spacing t1=%0d t2=%0d want 2 apart", t1, t2);
    else passed++;
    total++;
    if (r1 !== 32'hA5A5A5A5 || err0 !== 1'b0) $display("FAIL l0_data r1=%h err=%b want a5a5a5a5/0", r1, err0);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic e; int lat; bit saw_ack;
    xact(1'b1, 32'h20, 32'h0, 4'hF, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0000CAFE; be = 4'hF;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy busy=%b want 0", busy);
    else passed++;
    saw_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack) saw_ack = 1'b1;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ack) saw_ack = 1'b1;
    end
    total++;
    if (saw_ack !== 1'b0) $display("FAIL rst_no_ack saw ack=1 want 0");
    else passed++;
    xact(1'b0, 32'h20, 32'd0, 4'h0, rd, e, lat);
    total++;
    if (rd !== 32'h0 || e !== 1'b0 || lat !== 3)
      $display("FAIL rst_discard rdata=%h err=%b lat=%0d want 0/0/3", rd, e, lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_back_to_back_l0();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
